alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU.
// Covers register ops, immediate ops and address generation, plus signed and
// unsigned 32x32 multiply. Every result and status flag is registered, so an
// operation sampled at one rising edge is visible on the outputs right after
// that edge. Opcodes or function codes that are not recognized leave all
// outputs unchanged.
module alu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_inp1,
    input  logic [31:0] ALU_inp2,
    input  logic [2:0]  opcode,
    input  logic [3:0]  fcode,
    output logic [31:0] ALUout,
    output logic [31:0] ALU_extout,
    output logic        carryFlag,
    output logic        zeroFlag,
    output logic        signFlag,
    output logic        overflowFlag
);

    // Internal operation selector produced by the opcode/fcode decoder
    typedef enum logic [3:0] {
        SEL_ADD  = 4'd0,
        SEL_COMP = 4'd1,
        SEL_AND  = 4'd2,
        SEL_XOR  = 4'd3,
        SEL_SHLL = 4'd4,
        SEL_SHRL = 4'd5,
        SEL_SHRA = 4'd6,
        SEL_SUB  = 4'd7,
        SEL_OR   = 4'd8,
        SEL_NOR  = 4'd9,
        SEL_SMUL = 4'd10,
        SEL_UMUL = 4'd11,
        SEL_NONE = 4'd15
    } op_sel_t;

    localparam logic [2:0] OPC_REG  = 3'b000;
    localparam logic [2:0] OPC_IMM  = 3'b001;
    localparam logic [2:0] OPC_ADDR = 3'b010;

    op_sel_t     op_sel;

    // Arithmetic datapath
    logic [32:0] add_wide;
    logic [32:0] sub_wide;
    logic [32:0] comp_wide;
    logic        add_ovf;
    logic        sub_ovf;
    logic        comp_ovf;

    // Shifter datapath; the extra bit captures the last bit shifted out
    logic [4:0]  shamt;
    logic [32:0] shl_wide;
    logic [32:0] shr_wide;
    logic [32:0] sra_wide;

    // Multiplier datapath
    logic signed [63:0] smul_prod;
    logic [63:0]        umul_prod;

    // Registered outputs and their next values
    logic [31:0] alu_out_q,  alu_out_d;
    logic [31:0] ext_out_q,  ext_out_d;
    logic        carry_q,    carry_d;
    logic        zero_q,     zero_d;
    logic        sign_q,     sign_d;
    logic        ovf_q,      ovf_d;

    // Decode opcode/fcode into a single operation select; anything unknown maps to SEL_NONE
    always_comb begin
        op_sel = SEL_NONE;
        unique case (opcode)
            OPC_REG: begin
                case (fcode)
                    4'b0000: op_sel = SEL_ADD;
                    4'b0001: op_sel = SEL_COMP;
                    4'b0010: op_sel = SEL_AND;
                    4'b0011: op_sel = SEL_XOR;
                    4'b0100: op_sel = SEL_SHLL;
                    4'b0101: op_sel = SEL_SHRL;
                    4'b0110: op_sel = SEL_SHRA;
                    4'b0111: op_sel = SEL_SUB;
                    4'b1000: op_sel = SEL_OR;
                    4'b1001: op_sel = SEL_NOR;
                    4'b1010: op_sel = SEL_SMUL;
                    4'b1011: op_sel = SEL_UMUL;
                    default: op_sel = SEL_NONE;
                endcase
            end
            OPC_IMM: begin
                case (fcode)
                    4'b0000: op_sel = SEL_ADD;
                    4'b0001: op_sel = SEL_COMP;
                    default: op_sel = SEL_NONE;
                endcase
            end
            // Load/store address generation is a plain add, whatever the fcode
            OPC_ADDR: op_sel = SEL_ADD;
            default:  op_sel = SEL_NONE;
        endcase
    end

    // Adder, subtractor and negator with carry-out and signed-overflow detection
    always_comb begin
        add_wide  = {1'b0, ALU_inp1} + {1'b0, ALU_inp2};
        // Subtraction as A + ~B + 1 so bit 32 reads directly as "no borrow"
        sub_wide  = {1'b0, ALU_inp1} + {1'b0, ~ALU_inp2} + 33'd1;
        // Two's complement of B; carry out only appears when B is zero
        comp_wide = {1'b0, ~ALU_inp2} + 33'd1;

        add_ovf  = (ALU_inp1[31] == ALU_inp2[31]) && (add_wide[31] != ALU_inp1[31]);
        sub_ovf  = (ALU_inp1[31] != ALU_inp2[31]) && (sub_wide[31] != ALU_inp1[31]);
        // Negation overflows only for the most negative value
        comp_ovf = (ALU_inp2 == 32'h8000_0000);
    end

    // Barrel shifts on B[4:0]; a guard bit on the outgoing side holds the last bit shifted out
    always_comb begin
        shamt    = ALU_inp2[4:0];
        shl_wide = {1'b0, ALU_inp1} << shamt;
        shr_wide = {ALU_inp1, 1'b0} >> shamt;
        sra_wide = $unsigned($signed({ALU_inp1, 1'b0}) >>> shamt);
    end

    // Full 64-bit products, signed and unsigned
    always_comb begin
        smul_prod = $signed({{32{ALU_inp1[31]}}, ALU_inp1}) *
                    $signed({{32{ALU_inp2[31]}}, ALU_inp2});
        umul_prod = {32'd0, ALU_inp1} * {32'd0, ALU_inp2};
    end

    // Select the result and flags for the decoded operation; unknown ops hold everything
    always_comb begin
        alu_out_d = alu_out_q;
        ext_out_d = ext_out_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;

        if (op_sel != SEL_NONE) begin
            // Defaults for a recognized single-word op; specific cases override below
            ext_out_d = 32'd0;
            carry_d   = 1'b0;
            ovf_d     = 1'b0;
            alu_out_d = 32'd0;

            case (op_sel)
                SEL_ADD: begin
                    alu_out_d = add_wide[31:0];
                    carry_d   = add_wide[32];
                    ovf_d     = add_ovf;
                end
                SEL_COMP: begin
                    alu_out_d = comp_wide[31:0];
                    carry_d   = comp_wide[32];
                    ovf_d     = comp_ovf;
                end
                SEL_SUB: begin
                    alu_out_d = sub_wide[31:0];
                    carry_d   = sub_wide[32];
                    ovf_d     = sub_ovf;
                end
                SEL_AND:  alu_out_d = ALU_inp1 & ALU_inp2;
                SEL_XOR:  alu_out_d = ALU_inp1 ^ ALU_inp2;
                SEL_OR:   alu_out_d = ALU_inp1 | ALU_inp2;
                SEL_NOR:  alu_out_d = ~(ALU_inp1 | ALU_inp2);
                SEL_SHLL: begin
                    alu_out_d = shl_wide[31:0];
                    carry_d   = shl_wide[32];
                end
                SEL_SHRL: begin
                    alu_out_d = shr_wide[32:1];
                    carry_d   = shr_wide[0];
                end
                SEL_SHRA: begin
                    alu_out_d = sra_wide[32:1];
                    carry_d   = sra_wide[0];
                end
                SEL_SMUL: begin
                    alu_out_d = smul_prod[31:0];
                    ext_out_d = smul_prod[63:32];
                end
                SEL_UMUL: begin
                    alu_out_d = umul_prod[31:0];
                    ext_out_d = umul_prod[63:32];
                end
                default: alu_out_d = alu_out_q;
            endcase

            // Zero and sign look at the full product for multiplies, the low word otherwise
            if (op_sel == SEL_SMUL || op_sel == SEL_UMUL) begin
                zero_d = ({ext_out_d, alu_out_d} == 64'd0);
                sign_d = ext_out_d[31];
            end else begin
                zero_d = (alu_out_d == 32'd0);
                sign_d = alu_out_d[31];
            end
        end
    end

    // Output registers; reset clears everything and wins over any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= 32'd0;
            ext_out_q <= 32'd0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            ext_out_q <= ext_out_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ALUout       = alu_out_q;
    assign ALU_extout   = ext_out_q;
    assign carryFlag    = carry_q;
    assign zeroFlag     = zero_q;
    assign signFlag     = sign_q;
    assign overflowFlag = ovf_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core.
// Each transaction pushes its expected outputs, packed as
// {extout, ALUout, carry, zero, sign, ovf}, into a queue when driven; the
// entry is popped and compared once the DUT has registered the result.
module tb_alu_core;

    logic        clk;
    logic        rst;
    logic [31:0] ALU_inp1;
    logic [31:0] ALU_inp2;
    logic [2:0]  opcode;
    logic [3:0]  fcode;
    logic [31:0] ALUout;
    logic [31:0] ALU_extout;
    logic        carryFlag;
    logic        zeroFlag;
    logic        signFlag;
    logic        overflowFlag;

    typedef struct {
        string       tag;
        logic [67:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [67:0] model_state;
    int          n_cmp;
    int          n_err;

    alu_core dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_inp1     (ALU_inp1),
        .ALU_inp2     (ALU_inp2),
        .opcode       (opcode),
        .fcode        (fcode),
        .ALUout       (ALUout),
        .ALU_extout   (ALU_extout),
        .carryFlag    (carryFlag),
        .zeroFlag     (zeroFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Single comparison point: counts, prints one line per transaction
    task automatic chk_val(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got ext=%h out=%h czsv=%b required ext=%h out=%h czsv=%b",
                     tag, got[67:36], got[35:4], got[3:0], exp[67:36], exp[35:4], exp[3:0]);
        end else begin
            $display("ok   %s: ext=%h out=%h czsv=%b", tag, got[67:36], got[35:4], got[3:0]);
        end
    endtask

    // Reference model built on 64-bit integer arithmetic
    function automatic logic [67:0] model(input logic [2:0] op, input logic [3:0] fc,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [67:0] prev);
        logic [31:0] lo, hi;
        logic        c, v, z, s;
        logic [63:0] p, t;
        longint      sa;
        longint      max_i, min_i;
        bit          ok, mul;
        logic [3:0]  f;
        logic [4:0]  sh;
        max_i = 64'sd2147483647;
        min_i = -max_i - 1;
        ok = 1'b1; mul = 1'b0;
        lo = '0; hi = '0; c = 1'b0; v = 1'b0;
        p = '0; t = '0; sa = 0;
        sh = b[4:0];
        f  = 4'hF;
        if (op == 3'b000) f = fc;
        else if (op == 3'b001 && fc <= 4'd1) f = fc;
        else if (op == 3'b010) f = 4'd0;
        else ok = 1'b0;
        if (ok) begin
            case (f)
                4'd0: begin
                    p  = {32'd0, a} + {32'd0, b};
                    lo = p[31:0]; c = p[32];
                    sa = longint'($signed(a)) + longint'($signed(b));
                    v  = (sa > max_i) || (sa < min_i);
                end
                4'd1: begin
                    lo = 32'd0 - b;
                    c  = (b == 32'd0);
                    v  = (b == 32'h8000_0000);
                end
                4'd2: lo = a & b;
                4'd3: lo = a ^ b;
                4'd4: begin
                    t  = {32'd0, a} << sh;
                    lo = t[31:0]; c = t[32];
                end
                4'd5: begin
                    lo = a >> sh;
                    c  = (sh == 5'd0) ? 1'b0 : a[sh - 5'd1];
                end
                4'd6: begin
                    lo = $signed(a) >>> sh;
                    c  = (sh == 5'd0) ? 1'b0 : a[sh - 5'd1];
                end
                4'd7: begin
                    lo = a - b;
                    c  = (a >= b);
                    sa = longint'($signed(a)) - longint'($signed(b));
                    v  = (sa > max_i) || (sa < min_i);
                end
                4'd8: lo = a | b;
                4'd9: lo = ~(a | b);
                4'd10: begin
                    sa = longint'($signed(a)) * longint'($signed(b));
                    p  = sa;
                    hi = p[63:32]; lo = p[31:0]; mul = 1'b1;
                end
                4'd11: begin
                    p  = {32'd0, a} * {32'd0, b};
                    hi = p[63:32]; lo = p[31:0]; mul = 1'b1;
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) return prev;
        z = mul ? ({hi, lo} == 64'd0) : (lo == 32'd0);
        s = mul ? hi[31] : lo[31];
        return {hi, lo, c, z, s, v};
    endfunction

    // Drive one op on the falling edge, push its expectation, compare after the next rising edge
    task automatic run_txn(input string tag, input bit r, input logic [2:0] op, input logic [3:0] fc,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit use_fixed, input logic [67:0] fixed);
        exp_t e;
        @(negedge clk);
        rst = r; opcode = op; fcode = fc; ALU_inp1 = a; ALU_inp2 = b;
        if (r)              model_state = '0;
        else if (use_fixed) model_state = fixed;
        else                model_state = model(op, fc, a, b, model_state);
        e.tag = tag;
        e.val = model_state;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk_val(e.tag, {ALU_extout, ALUout, carryFlag, zeroFlag, signFlag, overflowFlag}, e.val);
    endtask

    // Directed transaction with a hand-written expectation
    task automatic dir(input string tag, input logic [2:0] op, input logic [3:0] fc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic [3:0] czsv);
        run_txn(tag, 1'b0, op, fc, a, b, 1'b1, {hi, lo, czsv});
    endtask

    logic [31:0] ra, rb;
    logic [31:0] edge_vals [6];

    initial begin
        n_cmp = 0; n_err = 0;
        model_state = '0;
        rst = 1'b1; opcode = 3'b000; fcode = 4'b0000; ALU_inp1 = '0; ALU_inp2 = '0;
        edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h0000_0001; edge_vals[5] = 32'h0000_001F;
        repeat (2) @(posedge clk);

        // Reset state while an add is presented
        run_txn("reset", 1'b1, 3'b000, 4'b0000, 32'd5, 32'd6, 1'b0, '0);

        //   tag          op      fc       A             B             hi            lo            czsv
        dir("add",       3'b000, 4'b0000, 32'd5,        32'd6,        32'd0,        32'd11,       4'b0000);
        dir("comp",      3'b000, 4'b0001, 32'd5,        32'd6,        32'd0,        32'hFFFFFFFA, 4'b0010);
        dir("and",       3'b000, 4'b0010, 32'd5,        32'd6,        32'd0,        32'd4,        4'b0000);
        dir("xor",       3'b000, 4'b0011, 32'd5,        32'd6,        32'd0,        32'd3,        4'b0000);
        dir("shll",      3'b000, 4'b0100, 32'd5,        32'd6,        32'd0,        32'd320,      4'b0000);
        dir("shrl",      3'b000, 4'b0101, 32'd5,        32'd6,        32'd0,        32'd0,        4'b0100);
        dir("shra",      3'b000, 4'b0110, 32'd5,        32'd6,        32'd0,        32'd0,        4'b0100);
        dir("sub",       3'b000, 4'b0111, 32'd5,        32'd6,        32'd0,        32'hFFFFFFFF, 4'b0010);
        dir("smul_small",3'b000, 4'b1010, 32'd5,        32'd6,        32'd0,        32'd30,       4'b0000);
        dir("add_ovf",   3'b000, 4'b0000, 32'h7FFFFFFF, 32'd1,        32'd0,        32'h80000000, 4'b0011);
        dir("add_carry", 3'b000, 4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        4'b1100);
        dir("smul_neg",  3'b000, 4'b1010, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 4'b0010);
        dir("umul",      3'b000, 4'b1011, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 4'b0000);
        dir("or",        3'b000, 4'b1000, 32'hF0F00000, 32'h0000000F, 32'd0,        32'hF0F0000F, 4'b0010);
        dir("nor",       3'b000, 4'b1001, 32'hFFFF0000, 32'h0000FFFF, 32'd0,        32'd0,        4'b0100);
        dir("comp_zero", 3'b000, 4'b0001, 32'd9,        32'd0,        32'd0,        32'd0,        4'b1100);
        dir("comp_min",  3'b000, 4'b0001, 32'd9,        32'h80000000, 32'd0,        32'h80000000, 4'b0011);
        dir("sub_eq",    3'b000, 4'b0111, 32'd7,        32'd7,        32'd0,        32'd0,        4'b1100);
        dir("shll_sh0",  3'b000, 4'b0100, 32'h80000001, 32'hFFFFFFE0, 32'd0,        32'h80000001, 4'b0010);
        dir("shll_up",   3'b000, 4'b0100, 32'h80000005, 32'h00000021, 32'd0,        32'd10,       4'b1000);
        dir("shra_neg",  3'b000, 4'b0110, 32'h80000003, 32'd2,        32'd0,        32'hE0000000, 4'b1010);
        dir("smul_zero", 3'b000, 4'b1010, 32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        4'b0100);
        dir("umul_pre",  3'b000, 4'b1011, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        4'b0000);
        dir("ext_clear", 3'b010, 4'b1111, 32'd5,        32'd6,        32'd0,        32'd11,       4'b0000);
        dir("hold_fc",   3'b000, 4'b1100, 32'd1,        32'd1,        32'd0,        32'd11,       4'b0000);
        dir("addi",      3'b001, 4'b0000, 32'd5,        32'd6,        32'd0,        32'd11,       4'b0000);
        dir("compi",     3'b001, 4'b0001, 32'd5,        32'd6,        32'd0,        32'hFFFFFFFA, 4'b0010);
        dir("hold_op7",  3'b111, 4'b0000, 32'd1,        32'd2,        32'd0,        32'hFFFFFFFA, 4'b0010);
        dir("hold_immf", 3'b001, 4'b0010, 32'd3,        32'd3,        32'd0,        32'hFFFFFFFA, 4'b0010);

        // Reset in the middle of a sequence discards the in-flight add
        run_txn("mid_reset", 1'b1, 3'b000, 4'b0000, 32'd100, 32'd200, 1'b0, '0);
        dir("post_reset", 3'b000, 4'b0000, 32'd5, 32'd6, 32'd0, 32'd11, 4'b0000);

        // Random mix against the reference model, biased toward edge operands
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            run_txn($sformatf("rand%0d", i), 1'b0, 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), ra, rb, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
